// File: rtl/nibble_loop_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_loop_sequencer_pkg
//  Description : Shared types for the nibble loop sequencer: ALU command and
//                control word, sequencer state encoding, nibble count type.
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_loop_sequencer_pkg;

    // Command executed by the nibble ALU loop
    typedef enum logic [1:0] {
        CMD_ADD   = 2'd0,
        CMD_SUB   = 2'd1,
        CMD_LSHFT = 2'd2,
        CMD_RSHFT = 2'd3
    } AluCmd;

    // Control word handed to the loop; only cmd is driven by the sequencer
    typedef struct packed {
        AluCmd cmd;
        logic  carry_in;
        logic  invert_word2;
    } AluCtrl;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } SeqState;

    // Operand length in nibbles minus one
    typedef logic [2:0] NibbleCount;

    // Sign bit of an operand of (w+1) nibbles sits at 4*w+3
    function automatic logic [4:0] sign_bit_index(input NibbleCount w);
        return {w, 2'b11};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_loop_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_loop_sequencer_if
//  Description : Requester/response bundle between the instruction-issue
//                logic (master) and the nibble loop sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface nibble_loop_sequencer_if
    import nibble_loop_sequencer_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    AluCmd [NREQ-1:0]       req_cmd;
    NibbleCount [NREQ-1:0]  req_width;
    logic [NREQ-1:0]        req_signed;
    logic [NREQ-1:0][31:0]  req_word1;
    logic [NREQ-1:0][31:0]  req_word2;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDX_W-1:0]       rsp_id;
    logic [31:0]            rsp_result;
    logic                   rsp_timeout;

    modport master (
        output req_valid, req_cmd, req_width, req_signed, req_word1, req_word2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_timeout
    );

    modport slave (
        input  req_valid, req_cmd, req_width, req_signed, req_word1, req_word2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_timeout
    );

endinterface
`default_nettype wire

// File: rtl/nibble_loop_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_loop_sequencer_rr_arbiter
//  Description : Round-robin arbiter. Searches the request vector starting at
//                the pointer; on an advance strobe with a winner, issues a
//                one-hot grant and moves the pointer just past the winner.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_loop_sequencer_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic [NREQ-1:0]           i_req,
    input  wire logic                      i_advance,
    output logic [NREQ-1:0]                o_grant,
    output logic [$clog2(NREQ)-1:0]        o_idx,
    output logic                           o_found
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_cand;

    // First pending request at or after the pointer, wrapping modulo NREQ
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        w_pos   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pos = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(NREQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NREQ);
            end
            w_cand = w_pos[IDX_W-1:0];
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (i_advance && o_found) begin
            o_grant[o_idx] = 1'b1;
        end
    end

    // Pointer moves to winner+1 only when a grant is actually issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_found) begin
            r_ptr <= (o_idx == IDX_W'(NREQ-1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nibble_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_loop_sequencer
//  Description : Shares one nibble ALU loop between NREQ requesters. Per
//                operation: arbitrate, latch operands, arm (reset) the loop,
//                run it until it goes idle or the watchdog fires, and return
//                the result through a valid/ready response.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_loop_sequencer
    import nibble_loop_sequencer_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int WATCHDOG = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    nibble_loop_sequencer_if.slave  bus,
    output logic                    loop_perm_to_count,
    output NibbleCount              loop_nibbles_number,
    output AluCtrl                  loop_ctrl,
    output logic                    word2_is_negative,
    output logic [31:0]             loop_word1,
    output logic [31:0]             loop_word2,
    output logic [31:0]             preinit_result,
    input  wire logic               loop_busy,
    input  wire logic [31:0]        loop_result
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(WATCHDOG + 1);

    SeqState          r_state;
    SeqState          w_next;
    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_found;
    logic             w_advance;
    logic             w_accept;
    logic             w_loop_done;
    logic             w_wd_expired;

    AluCmd            r_cmd;
    NibbleCount       r_width;
    logic             r_signed;
    logic [31:0]      r_word1;
    logic [31:0]      r_word2;
    logic [IDX_W-1:0] r_id;
    logic [31:0]      r_result;
    logic             r_timeout;
    logic [WD_W-1:0]  r_wd;

    // Grants are only offered in IDLE (rsp_valid is necessarily low there)
    // and never while reset is asserted.
    assign w_advance = (r_state == IDLE) && rst_n;
    assign w_accept  = |w_grant;

    nibble_loop_sequencer_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_valid),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_idx     (w_win_idx),
        .o_found   (w_found)
    );

    // Busy is ignored on the first RUN cycle (watchdog still 0) because the
    // loop has not yet had a chance to raise it after being armed.
    assign w_loop_done  = (r_state == RUN) && (r_wd != '0) && !loop_busy;
    assign w_wd_expired = (r_state == RUN) && !w_loop_done && (r_wd == WD_W'(WATCHDOG - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/loop control outputs
    always_comb begin
        w_next             = r_state;
        bus.req_ready      = '0;
        bus.rsp_valid      = 1'b0;
        loop_perm_to_count = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = w_grant;
                if (w_accept) begin
                    w_next = ARM;
                end
            end
            ARM: begin
                w_next = RUN;
            end
            RUN: begin
                loop_perm_to_count = 1'b1;
                if (w_loop_done || w_wd_expired) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                loop_perm_to_count = 1'b1;
                bus.rsp_valid      = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand latch on the accepting cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd    <= CMD_ADD;
            r_width  <= '0;
            r_signed <= 1'b0;
            r_word1  <= '0;
            r_word2  <= '0;
            r_id     <= '0;
        end else if (w_accept) begin
            r_cmd    <= bus.req_cmd[w_win_idx];
            r_width  <= bus.req_width[w_win_idx];
            r_signed <= bus.req_signed[w_win_idx];
            r_word1  <= bus.req_word1[w_win_idx];
            r_word2  <= bus.req_word2[w_win_idx];
            r_id     <= w_win_idx;
        end
    end

    // Watchdog: cleared while arming, counts RUN cycles until the op ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (r_state == ARM) begin
            r_wd <= '0;
        end else if ((r_state == RUN) && !w_loop_done && !w_wd_expired) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Result capture: loop result on completion, zero plus flag on abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else if (w_loop_done) begin
            r_result  <= loop_result;
            r_timeout <= 1'b0;
        end else if (w_wd_expired) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
        end
    end

    // Loop control word carries only the command
    always_comb begin
        loop_ctrl     = '0;
        loop_ctrl.cmd = r_cmd;
    end

    assign bus.rsp_id          = r_id;
    assign bus.rsp_result      = r_result;
    assign bus.rsp_timeout     = r_timeout;
    assign loop_nibbles_number = r_width;
    assign loop_word1          = r_word1;
    assign loop_word2          = r_word2;
    assign word2_is_negative   = r_signed & r_word2[sign_bit_index(r_width)];
    // A right shift accumulates into an empty result; everything else
    // starts from word1.
    assign preinit_result      = (r_cmd == CMD_RSHFT) ? 32'h0 : r_word1;

endmodule
`default_nettype wire

// File: tb/tb_nibble_loop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_loop_sequencer
//  Description : Self-checking bench for nibble_loop_sequencer with a
//                behavioural stand-in for the nibble ALU loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_loop_sequencer;
    import nibble_loop_sequencer_pkg::*;

    localparam int NREQ     = 2;
    localparam int WATCHDOG = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        perm;
    NibbleCount  nib;
    AluCtrl      ctrl;
    logic        w2neg;
    logic [31:0] lw1;
    logic [31:0] lw2;
    logic [31:0] pre;
    logic        busy;
    logic [31:0] lres;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr_m    = 0;

    always #5 clk = ~clk;

    nibble_loop_sequencer_if #(.NREQ(NREQ)) ifc ();

    nibble_loop_sequencer #(
        .NREQ     (NREQ),
        .WATCHDOG (WATCHDOG)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (ifc),
        .loop_perm_to_count  (perm),
        .loop_nibbles_number (nib),
        .loop_ctrl           (ctrl),
        .word2_is_negative   (w2neg),
        .loop_word1          (lw1),
        .loop_word2          (lw2),
        .preinit_result      (pre),
        .loop_busy           (busy),
        .loop_result         (lres)
    );

    // Loop stand-in: loads preinit while perm=0, then stays busy for
    // stub_lat counting cycles and presents the finished word.
    int          stub_lat = 0;
    int          stub_cnt = 0;
    logic [31:0] stub_acc = '0;

    always @(posedge clk) begin
        if (!perm) begin
            stub_cnt <= 0;
            stub_acc <= pre;
        end else if (stub_cnt < 1000000) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign busy = (stub_cnt < stub_lat);

    always_comb begin
        logic [31:0] m;
        m = 32'hFFFF_FFFF >> (4 * (7 - int'(nib)));
        if (ctrl.cmd == CMD_RSHFT) lres = stub_acc + (lw2 >> 1);
        else                       lres = stub_acc + (w2neg ? (lw2 | ~m) : lw2);
    end

    // Reference rules, computed from the request itself
    function automatic logic [31:0] ext_w2(NibbleCount w, logic s, logic [31:0] v);
        int sb;
        sb = 4 * int'(w) + 3;
        if (s && v[sb]) begin
            for (int b = sb + 1; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic exp_neg(NibbleCount w, logic s, logic [31:0] v);
        return s && v[4 * int'(w) + 3];
    endfunction

    function automatic logic [31:0] exp_result(AluCmd c, NibbleCount w, logic s,
                                               logic [31:0] a, logic [31:0] b);
        if (c == CMD_RSHFT) return b >> 1;
        return a + ext_w2(w, s, b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_req(input int id, input AluCmd c, input NibbleCount w, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        ifc.req_cmd[id]    = c;
        ifc.req_width[id]  = w;
        ifc.req_signed[id] = s;
        ifc.req_word1[id]  = a;
        ifc.req_word2[id]  = b;
    endtask

    // One full operation; called and returns at posedge+1.
    task automatic run_one(input int lat, input int delay, input bit keep, input bit expect_now);
        int          eid;
        int          waited;
        int          runs;
        int          runs_exp;
        int          leaks;
        int          unstable;
        int          k;
        bit          got;
        bit          eto;
        logic [31:0] er;
        AluCtrl      ectrl;
        eid = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (eid < 0 && ifc.req_valid[(ptr_m + i) % NREQ]) eid = (ptr_m + i) % NREQ;
        end
        if (eid < 0) begin
            check("no requester valid", 0, 1);
            return;
        end
        k        = (lat < 1) ? 1 : lat;
        eto      = (k >= WATCHDOG);
        runs_exp = eto ? WATCHDOG : k + 1;
        er       = eto ? 32'h0 : exp_result(ifc.req_cmd[eid], ifc.req_width[eid], ifc.req_signed[eid],
                                           ifc.req_word1[eid], ifc.req_word2[eid]);
        ectrl     = '0;
        ectrl.cmd = ifc.req_cmd[eid];
        stub_lat  = lat;
        got = 0;
        waited = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (ifc.req_ready != '0) begin
                got = 1;
                break;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        check("accept seen", 32'(got), 1);
        if (!got) return;
        if (expect_now) check("accept right after handshake", waited, 0);
        check("grant one-hot", 32'(ifc.req_ready), 32'(1 << eid));
        ptr_m = (eid + 1) % NREQ;
        @(posedge clk);
        #1;
        if (!keep) ifc.req_valid[eid] = 1'b0;
        @(negedge clk);
        check("ARM perm", 32'(perm), 0);
        check("ARM req_ready", 32'(ifc.req_ready), 0);
        check("nibbles", 32'(nib), 32'(ifc.req_width[eid]));
        check("ctrl", 32'(ctrl), 32'(ectrl));
        check("word2_is_negative", 32'(w2neg),
              32'(exp_neg(ifc.req_width[eid], ifc.req_signed[eid], ifc.req_word2[eid])));
        check("loop_word1", lw1, ifc.req_word1[eid]);
        check("loop_word2", lw2, ifc.req_word2[eid]);
        check("preinit", pre, (ifc.req_cmd[eid] == CMD_RSHFT) ? 32'h0 : ifc.req_word1[eid]);
        runs = 0;
        leaks = 0;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (ifc.req_ready != '0) leaks++;
            if (ifc.rsp_valid) begin
                got = 1;
                break;
            end
            if (perm) runs++;
        end
        check("rsp seen", 32'(got), 1);
        if (!got) return;
        check("RUN cycles", runs, runs_exp);
        check("no grant while busy", leaks, 0);
        check("DONE perm", 32'(perm), 1);
        check("rsp_id", 32'(ifc.rsp_id), eid);
        check("rsp_result", ifc.rsp_result, er);
        check("rsp_timeout", 32'(ifc.rsp_timeout), 32'(eto));
        unstable = 0;
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (!ifc.rsp_valid || int'(ifc.rsp_id) != eid || ifc.rsp_result !== er ||
                ifc.rsp_timeout !== eto || ifc.req_ready != '0) unstable++;
        end
        if (delay > 0) check("DONE hold stable", unstable, 0);
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b0;
        check("rsp_valid drops", 32'(ifc.rsp_valid), 0);
    endtask

    initial begin
        bit first;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b0;
        for (int r = 0; r < NREQ; r++) set_req(r, CMD_ADD, 3'd0, 1'b0, 32'h0, 32'h0);
        #12;
        check("reset perm", 32'(perm), 0);
        check("reset rsp_valid", 32'(ifc.rsp_valid), 0);
        check("reset req_ready", 32'(ifc.req_ready), 0);
        check("reset rsp_result", ifc.rsp_result, 0);
        check("reset rsp_timeout", 32'(ifc.rsp_timeout), 0);
        check("reset loop_word1", lw1, 0);
        check("reset preinit", pre, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-width unsigned add with a long carry chain
        set_req(0, CMD_ADD, 3'd7, 1'b0, 32'h0EFF_FFFF, 32'h1);
        ifc.req_valid[0] = 1'b1;
        run_one(3, 0, 0, 0);

        // Signed two-nibble operand, negative
        set_req(0, CMD_ADD, 3'd1, 1'b1, 32'h0000_FFFF, 32'h0000_00FF);
        ifc.req_valid[0] = 1'b1;
        run_one(2, 1, 0, 0);

        // Width 0: carry propagates beyond the operand width
        set_req(1, CMD_ADD, 3'd0, 1'b0, 32'h0000_0AFF, 32'h1);
        ifc.req_valid[1] = 1'b1;
        run_one(1, 0, 0, 0);
        set_req(1, CMD_RSHFT, 3'd7, 1'b0, 32'h1234_5678, 32'h0600_0000);
        ifc.req_valid[1] = 1'b1;
        run_one(0, 0, 0, 0);

        // Both requesters contending for four ops: grants alternate
        set_req(0, CMD_ADD, 3'd3, 1'b0, 32'h0000_1111, 32'h0000_0222);
        set_req(1, CMD_RSHFT, 3'd5, 1'b0, 32'h0, 32'h0088_0000);
        ifc.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) run_one(2, 0, 1, i > 0);
        ifc.req_valid = '0;

        // Slow consumer while another request waits
        set_req(0, CMD_ADD, 3'd2, 1'b1, 32'h0000_0100, 32'h0000_0800);
        set_req(1, CMD_ADD, 3'd4, 1'b0, 32'h0001_0000, 32'h0000_1234);
        ifc.req_valid = 2'b11;
        run_one(4, 5, 0, 0);
        run_one(1, 0, 0, 1);

        // Loop never finishes: watchdog abort
        set_req(0, CMD_ADD, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'h1);
        ifc.req_valid[0] = 1'b1;
        run_one(1000, 2, 0, 0);

        // Reset in the middle of RUN
        set_req(1, CMD_ADD, 3'd7, 1'b0, 32'h5, 32'h6);
        ifc.req_valid[1] = 1'b1;
        stub_lat = 1000;
        first = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (ifc.req_ready != '0) begin
                first = 1;
                break;
            end
        end
        check("mid-reset accept seen", 32'(first), 1);
        @(posedge clk);
        #1;
        ifc.req_valid = '0;
        repeat (4) @(posedge clk);
        #2;
        check("pre-reset perm", 32'(perm), 1);
        rst_n = 1'b0;
        #1;
        check("mid-reset perm", 32'(perm), 0);
        check("mid-reset rsp_valid", 32'(ifc.rsp_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ptr_m = 0;
        set_req(1, CMD_ADD, 3'd7, 1'b0, 32'h0000_0010, 32'h0000_0020);
        ifc.req_valid[1] = 1'b1;
        run_one(2, 0, 0, 0);

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!ifc.req_valid[r]) begin
                    NibbleCount w;
                    logic [31:0] m;
                    w = NibbleCount'($urandom_range(0, 7));
                    m = 32'hFFFF_FFFF >> (4 * (7 - int'(w)));
                    set_req(r, ($urandom_range(0, 1) == 1) ? CMD_RSHFT : CMD_ADD, w,
                            1'($urandom_range(0, 1)), $urandom, $urandom & m);
                    ifc.req_valid[r] = 1'($urandom_range(0, 1));
                end
            end
            if (ifc.req_valid == '0) ifc.req_valid[$urandom_range(0, NREQ - 1)] = 1'b1;
            run_one($urandom_range(0, 7), $urandom_range(0, 3), 0, it > 0);
        end
        ifc.req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global time limit: observed still running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
